tb_stream_pattern_gen: RTL and testbench

//  Bench-side stream source instantiated inside tb_main, driven by the clk and

---
 rtl/tb_stream_pattern_gen_if.sv | 12 +
 rtl/tb_stream_pattern_gen.sv | 114 +++++++++++
 tb/tb_tb_stream_pattern_gen.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tb_stream_pattern_gen_if.sv
// Valid/ready/last stream bundle between the pattern source and its consumer.
interface tb_stream_pattern_gen_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] data;
   logic                  last;
   logic                  valid;
   logic                  ready;

   modport master (output data, output last, output valid, input ready);
   modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/tb_stream_pattern_gen.sv
// Bench-side stream source: NUM_FRAMES frames of incrementing beats with
// LFSR-throttled valid, plus run progress counters for sequencing.
module tb_stream_pattern_gen #(
   parameter int unsigned           DATA_WIDTH = 16,
   parameter int unsigned           FRAME_LEN  = 16,
   parameter int unsigned           NUM_FRAMES = 4,
   parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0,
   parameter int unsigned           VALID_RATE = 16,
   parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   tb_stream_pattern_gen_if.master m,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             frame_count,
   output logic [31:0]             beat_count
);
   localparam int unsigned        IDX_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(FRAME_LEN - 1);
   localparam logic [31:0]        FRAME_LAST = 32'(NUM_FRAMES - 1);
   localparam logic [4:0]         RATE       = 5'(VALID_RATE);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [31:0]           fc_q, fc_d;
   logic [31:0]           bc_q, bc_d;
   logic                  xfer;
   logic                  final_beat;
   logic                  fb;

   assign xfer       = valid_q & m.ready;
   assign final_beat = (NUM_FRAMES != 0) && (idx_q == IDX_LAST) && (fc_q == FRAME_LAST);
   assign fb         = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= LFSR_SEED;
         valid_q <= 1'b0;
         data_q  <= INIT_DATA;
         idx_q   <= '0;
         fc_q    <= '0;
         bc_q    <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         fc_q    <= fc_d;
         bc_q    <= bc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      valid_d = valid_q;
      data_d  = data_q;
      idx_d   = idx_q;
      fc_d    = fc_q;
      bc_d    = bc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               lfsr_d  = LFSR_SEED;
               valid_d = 1'b0;
               data_d  = INIT_DATA;
               idx_d   = '0;
               fc_d    = '0;
               bc_d    = '0;
            end
         end
         S_RUN: begin
            lfsr_d = {lfsr_q[14:0], fb};
            if (xfer) begin
               data_d = data_q + DATA_WIDTH'(1);
               bc_d   = bc_q + 32'd1;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  fc_d  = fc_q + 32'd1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            // A new valid decision is only taken when no beat is pending,
            // so a stalled beat stays presented until it is accepted.
            if (xfer && final_beat) begin
               state_d = S_DONE;
               valid_d = 1'b0;
            end else if (!valid_q || xfer) begin
               valid_d = ({1'b0, lfsr_q[3:0]} < RATE);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign m.valid     = valid_q;
   assign m.data      = data_q;
   assign m.last      = valid_q && (idx_q == IDX_LAST);
   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign frame_count = fc_q;
   assign beat_count  = bc_q;
endmodule

// File: tb/tb_tb_stream_pattern_gen.sv
// Directed-plus-random checks of the stream pattern source against a
// beat-count based reference model.
module tb_tb_stream_pattern_gen;
   logic        clk;
   logic        reset_n;
   logic        start;
   logic        ready;
   int          sel;

   int unsigned checks = 0;
   int unsigned fails  = 0;

   // Configurations of the three instances: 0 = back-to-back, 1 = throttled, 2 = narrow wrap
   int unsigned cfg_fl   [3] = '{4, 16, 4};
   int unsigned cfg_nf   [3] = '{2, 4, 1};
   int unsigned cfg_rate [3] = '{16, 8, 16};
   int unsigned cfg_init [3] = '{0, 0, 14};
   int unsigned cfg_dw   [3] = '{16, 16, 4};

   logic [15:0] seq [4096];
   logic        rdy_pat [512];

   // Reference model state: 0 idle, 1 run, 2 done
   int          mstate;
   bit          mv;
   int unsigned acc;
   int unsigned n;
   int unsigned gaps;

   logic        st_a, st_b, st_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic [31:0] fc_a, fc_b, fc_c, bc_a, bc_b, bc_c;
   logic [31:0] obs_valid, obs_data, obs_last, obs_busy, obs_done, obs_fc, obs_bc;

   tb_stream_pattern_gen_if #(.DATA_WIDTH(16)) ifa ();
   tb_stream_pattern_gen_if #(.DATA_WIDTH(16)) ifb ();
   tb_stream_pattern_gen_if #(.DATA_WIDTH(4))  ifc ();

   assign st_a = start && (sel == 0);
   assign st_b = start && (sel == 1);
   assign st_c = start && (sel == 2);
   assign ifa.ready = ready;
   assign ifb.ready = ready;
   assign ifc.ready = ready;

   tb_stream_pattern_gen #(
      .DATA_WIDTH(16), .FRAME_LEN(4), .NUM_FRAMES(2), .INIT_DATA(16'd0),
      .VALID_RATE(16), .LFSR_SEED(16'hACE1)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .start(st_a), .m(ifa.master),
      .busy(busy_a), .done(done_a), .frame_count(fc_a), .beat_count(bc_a)
   );

   tb_stream_pattern_gen #(
      .DATA_WIDTH(16), .FRAME_LEN(16), .NUM_FRAMES(4), .INIT_DATA(16'd0),
      .VALID_RATE(8), .LFSR_SEED(16'hACE1)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .start(st_b), .m(ifb.master),
      .busy(busy_b), .done(done_b), .frame_count(fc_b), .beat_count(bc_b)
   );

   tb_stream_pattern_gen #(
      .DATA_WIDTH(4), .FRAME_LEN(4), .NUM_FRAMES(1), .INIT_DATA(4'd14),
      .VALID_RATE(16), .LFSR_SEED(16'hACE1)
   ) dut_c (
      .clk(clk), .reset_n(reset_n), .start(st_c), .m(ifc.master),
      .busy(busy_c), .done(done_c), .frame_count(fc_c), .beat_count(bc_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      obs_valid = '0; obs_data = '0; obs_last = '0; obs_busy = '0;
      obs_done = '0; obs_fc = '0; obs_bc = '0;
      case (sel)
         0: begin
            obs_valid = {31'b0, ifa.valid}; obs_data = {16'b0, ifa.data};
            obs_last = {31'b0, ifa.last}; obs_busy = {31'b0, busy_a};
            obs_done = {31'b0, done_a}; obs_fc = fc_a; obs_bc = bc_a;
         end
         1: begin
            obs_valid = {31'b0, ifb.valid}; obs_data = {16'b0, ifb.data};
            obs_last = {31'b0, ifb.last}; obs_busy = {31'b0, busy_b};
            obs_done = {31'b0, done_b}; obs_fc = fc_b; obs_bc = bc_b;
         end
         default: begin
            obs_valid = {31'b0, ifc.valid}; obs_data = {28'b0, ifc.data};
            obs_last = {31'b0, ifc.last}; obs_busy = {31'b0, busy_c};
            obs_done = {31'b0, done_c}; obs_fc = fc_c; obs_bc = bc_c;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string pfx);
      int unsigned fl;
      logic [31:0] mask;
      fl   = cfg_fl[sel];
      mask = 32'((64'd1 << cfg_dw[sel]) - 64'd1);
      check({pfx, "_valid"}, obs_valid, 32'(mv));
      check({pfx, "_data"},  obs_data,  (cfg_init[sel] + acc) & mask);
      check({pfx, "_last"},  obs_last,  32'(mv && ((acc % fl) == fl - 1)));
      check({pfx, "_busy"},  obs_busy,  32'(mstate == 1));
      check({pfx, "_done"},  obs_done,  32'(mstate == 2));
      check({pfx, "_fc"},    obs_fc,    acc / fl);
      check({pfx, "_bc"},    obs_bc,    acc);
   endtask

   task automatic model_reset();
      mstate = 0; mv = 1'b0; acc = 0; n = 0;
   endtask

   // One clock: drive inputs, advance the model for that edge, compare.
   task automatic step(input logic r, input logic st);
      bit xfer;
      ready = r;
      start = st;
      @(posedge clk);
      #1;
      if (mstate != 1) begin
         if (st) begin
            mstate = 1; mv = 1'b0; acc = 0; n = 0;
         end
      end else begin
         xfer = mv && r;
         if (xfer) acc++;
         if (xfer && cfg_nf[sel] != 0 && acc == cfg_fl[sel] * cfg_nf[sel]) begin
            mv = 1'b0;
            mstate = 2;
         end else if (!mv || xfer) begin
            mv = ({28'b0, seq[n][3:0]} < cfg_rate[sel]);
         end
         n++;
      end
      compare_all("cyc");
   endtask

   task automatic run_until_done(input int mode, input int poke, input int limit);
      int unsigned bp;
      bp   = 0;
      gaps = 0;
      for (int cyc = 0; cyc < limit && mstate != 2; cyc++) begin
         logic r;
         case (mode)
            0: r = 1'b1;
            1: r = rdy_pat[cyc % 512];
            default: begin
               if (mv && acc >= 2 && bp < 5) begin
                  r = 1'b0;
                  bp++;
               end else begin
                  r = 1'b1;
               end
            end
         endcase
         step(r, cyc == poke);
         if (obs_busy[0] && !obs_valid[0]) gaps++;
      end
      check("run_done", obs_done, 32'd1);
      start = 1'b0;
   endtask

   initial begin
      seq[0] = 16'hACE1;
      for (int i = 1; i < 4096; i++)
         seq[i] = {seq[i-1][14:0], ^(seq[i-1] & 16'hB400)};
      for (int i = 0; i < 512; i++)
         rdy_pat[i] = 1'($urandom_range(0, 1));

      reset_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 0;
      model_reset();
      #12;
      compare_all("rst");
      @(posedge clk); #1;
      reset_n = 1'b1;
      step(1'b1, 1'b0);

      // Back-to-back: 2 frames of 4 beats
      step(1'b1, 1'b1);
      run_until_done(0, -1, 40);
      check("t2_fc", obs_fc, 32'd2);
      check("t2_bc", obs_bc, 32'd8);

      // Restart from DONE with a 5-cycle stall and a start pulse mid-run
      step(1'b1, 1'b1);
      run_until_done(2, 6, 60);
      check("t3_bc", obs_bc, 32'd8);

      // Throttled valid with random ready, twice for repeatability
      sel = 1;
      model_reset();
      step(1'b0, 1'b0);
      for (int run = 0; run < 2; run++) begin
         step(1'b0, 1'b1);
         run_until_done(1, -1, 2000);
         check("t4_gaps", 32'(gaps != 0), 32'd1);
         check("t4_bc", obs_bc, 32'd64);
      end

      // Reset in the middle of a run, with a beat pending
      step(1'b0, 1'b1);
      for (int i = 0; i < 15; i++) step(rdy_pat[i], 1'b0);
      for (int i = 0; i < 50 && !mv; i++) step(1'b0, 1'b0);
      check("pre_rst_valid", obs_valid, 32'd1);
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all("midrst");
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      run_until_done(1, -1, 2000);

      // Narrow data path wraps 14,15,0,1
      sel = 2;
      model_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      run_until_done(0, -1, 20);
      check("t5_bc", obs_bc, 32'd4);
      check("t5_data", obs_data, 32'd2);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
